// File: rtl/rca_multiword_seq.sv
// Multi-cycle wide adder: one BITS-wide ripple-carry adder is reused across WORDS
// chunks, LSB first, with the inter-chunk carry held in a register.

module rca #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            c_in,
    output logic [BITS-1:0] s,
    output logic            c_out
);
    logic [BITS:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int i = 0; i < BITS; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = c[BITS];
endmodule

module rca_multiword_seq #(
    parameter int BITS  = 32,
    parameter int WORDS = 4,
    localparam int W    = BITS * WORDS
) (
    input  logic         _clk,
    input  logic         _rst,
    input  logic         _valid_in,
    output logic         _ready_out,
    input  logic [W-1:0] _a_in,
    input  logic [W-1:0] _b_in,
    input  logic         _c_in,
    output logic         _valid_out,
    input  logic         _ready_in,
    output logic [W-1:0] _s_out,
    output logic         _c_out,
    output logic         _ovf_out
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_reg, b_reg, s_reg;
    logic [CW-1:0]   cnt;
    logic            carry_reg, c_reg, ovf_reg;
    logic            accept, last;
    logic [BITS-1:0] a_chunk, b_chunk, sum_chunk;
    logic            carry_chunk;

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign accept  = _valid_in && _ready_out;
    assign last    = (cnt == CW'(WORDS - 1));
    assign a_chunk = a_reg[int'(cnt) * BITS +: BITS];
    assign b_chunk = b_reg[int'(cnt) * BITS +: BITS];

    rca #(.BITS(BITS)) u_rca (
        .a     (a_chunk),
        .b     (b_chunk),
        .c_in  (carry_reg),
        .s     (sum_chunk),
        .c_out (carry_chunk)
    );

    always_ff @(posedge _clk) begin
        if (_rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)   state_nxt = RUN;
            RUN:     if (last)     state_nxt = DONE;
            DONE:    if (_ready_in) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Operand capture: data only, meaningless until the next accept
    always_ff @(posedge _clk) begin
        if (accept) begin
            a_reg <= _a_in;
            b_reg <= _b_in;
        end
    end

    always_ff @(posedge _clk) begin
        if (_rst) begin
            cnt       <= '0;
            carry_reg <= 1'b0;
            s_reg     <= '0;
            c_reg     <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= '0;
                        carry_reg <= _c_in;
                    end
                end
                RUN: begin
                    s_reg[int'(cnt) * BITS +: BITS] <= sum_chunk;
                    carry_reg <= carry_chunk;
                    if (last) begin
                        cnt     <= '0;
                        c_reg   <= carry_chunk;
                        ovf_reg <= signed_ovf(a_chunk[BITS-1], b_chunk[BITS-1], sum_chunk[BITS-1]);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The IDLE-only ready is masked by reset so nothing is accepted in a reset cycle
    assign _ready_out = (state == IDLE) && !_rst;
    assign _valid_out = (state == DONE);
    assign _s_out     = s_reg;
    assign _c_out     = c_reg;
    assign _ovf_out   = ovf_reg;
endmodule

// File: tb/tb_rca_multiword_seq.sv
// Bench for rca_multiword_seq: directed corner cases plus randomized traffic on a
// 32x4 instance and an 8x1 instance, checked by a queue-based scoreboard.

module tb_rca_multiword_seq;
    localparam int BITS   = 32;
    localparam int WORDS  = 4;
    localparam int W      = BITS * WORDS;
    localparam int BITS2  = 8;
    localparam int WORDS2 = 1;
    localparam int W2     = BITS2 * WORDS2;
    localparam int NRAND  = 2000;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         ovf;
    } exp1_t;

    typedef struct packed {
        logic [W2-1:0] s;
        logic          c;
        logic          ovf;
    } exp2_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          valid_in, ready_out, c_in, valid_out, ready_in, c_out, ovf_out;
    logic [W-1:0]  a_in, b_in, s_out;
    logic          valid_in2, ready_out2, c_in2, valid_out2, ready_in2, c_out2, ovf_out2;
    logic [W2-1:0] a_in2, b_in2, s_out2;

    int    errors = 0, checks = 0;
    int    sent1 = 0, res1 = 0, sent2 = 0, res2 = 0;
    bit    rand_rdy1 = 1'b0;
    exp1_t q1[$];
    exp2_t q2[$];

    rca_multiword_seq #(.BITS(BITS), .WORDS(WORDS)) dut (
        ._clk(clk), ._rst(rst), ._valid_in(valid_in), ._ready_out(ready_out),
        ._a_in(a_in), ._b_in(b_in), ._c_in(c_in), ._valid_out(valid_out),
        ._ready_in(ready_in), ._s_out(s_out), ._c_out(c_out), ._ovf_out(ovf_out)
    );

    rca_multiword_seq #(.BITS(BITS2), .WORDS(WORDS2)) dut2 (
        ._clk(clk), ._rst(rst), ._valid_in(valid_in2), ._ready_out(ready_out2),
        ._a_in(a_in2), ._b_in(b_in2), ._c_in(c_in2), ._valid_out(valid_out2),
        ._ready_in(ready_in2), ._s_out(s_out2), ._c_out(c_out2), ._ovf_out(ovf_out2)
    );

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp1_t model1(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] t;
        exp1_t      e;
        t     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.s   = t[W-1:0];
        e.c   = t[W];
        e.ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic exp2_t model2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c);
        logic [W2:0] t;
        exp2_t       e;
        t     = {1'b0, a} + {1'b0, b} + {{W2{1'b0}}, c};
        e.s   = t[W2-1:0];
        e.c   = t[W2];
        e.ovf = (a[W2-1] == b[W2-1]) && (t[W2-1] != a[W2-1]);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = '1;
            1: v = '0;
            2: v = {1'b0, {(W-1){1'b1}}};
            3: v = {1'b1, {(W-1){1'b0}}};
            default: ;
        endcase
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send1(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bit ok = 1'b0;
        valid_in = 1'b1; a_in = a; b_in = b; c_in = c;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ready_out) begin ok = 1'b1; break; end
        end
        if (ok) begin
            q1.push_back(model1(a, b, c));
            sent1++;
        end else begin
            chk("dut1_accept_timeout", 0, 1);
        end
        @(posedge clk); #1;
        valid_in = 1'b0; a_in = rnd_word(); b_in = rnd_word(); c_in = 1'($urandom);
    endtask

    task automatic send2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c);
        bit ok = 1'b0;
        valid_in2 = 1'b1; a_in2 = a; b_in2 = b; c_in2 = c;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ready_out2) begin ok = 1'b1; break; end
        end
        if (ok) begin
            q2.push_back(model2(a, b, c));
            sent2++;
        end else begin
            chk("dut2_accept_timeout", 0, 1);
        end
        @(posedge clk); #1;
        valid_in2 = 1'b0; a_in2 = W2'($urandom); b_in2 = W2'($urandom);
    endtask

    task automatic wait_idle1();
        for (int k = 0; k < 50 && !ready_out; k++) @(negedge clk);
        chk("dut1_return_idle", (W+1)'(ready_out), 1);
        @(posedge clk); #1;
    endtask

    task automatic rand1();
        logic [W-1:0] a, b;
        rand_rdy1 = 1'b1;
        for (int n = 0; n < NRAND; n++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            a = rnd_word();
            b = ($urandom_range(0, 3) == 0) ? ~a : rnd_word();
            send1(a, b, 1'($urandom));
        end
    endtask

    task automatic rand2();
        logic [W2-1:0] a, b;
        for (int n = 0; n < NRAND; n++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            a = W2'($urandom);
            b = ($urandom_range(0, 3) == 0) ? ~a : W2'($urandom);
            send2(a, b, 1'($urandom));
        end
    endtask

    // Scoreboard monitors: a result is consumed on valid_out && ready_in
    always @(negedge clk) begin
        exp1_t e;
        if (!rst && valid_out && ready_in) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_result", (W+1)'(s_out), 0);
                chk("dut1_unexpected_result_count", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("dut1_sum", (W+1)'(s_out), (W+1)'(e.s));
                chk("dut1_cout", (W+1)'(c_out), (W+1)'(e.c));
                chk("dut1_ovf", (W+1)'(ovf_out), (W+1)'(e.ovf));
                res1++;
            end
        end
    end

    always @(negedge clk) begin
        exp2_t e;
        if (!rst && valid_out2 && ready_in2) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_result", (W+1)'(s_out2), 0);
                chk("dut2_unexpected_result_count", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("dut2_sum", (W+1)'(s_out2), (W+1)'(e.s));
                chk("dut2_cout", (W+1)'(c_out2), (W+1)'(e.c));
                chk("dut2_ovf", (W+1)'(ovf_out2), (W+1)'(e.ovf));
                res2++;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy1) ready_in = ($urandom_range(0, 3) != 0);
        ready_in2 = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hs;
        logic         hc, hovf;
        int           lat;

        rst = 1'b1; ready_in = 1'b1;
        valid_in = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
        valid_in2 = 1'b0; a_in2 = '0; b_in2 = '0; c_in2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ready_out", (W+1)'(ready_out), 0);
        chk("reset_valid_out", (W+1)'(valid_out), 0);
        chk("reset_s_out", (W+1)'(s_out), 0);
        chk("reset_c_out", (W+1)'(c_out), 0);
        chk("reset_ovf_out", (W+1)'(ovf_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready_out", (W+1)'(ready_out), 1);
        @(posedge clk); #1;

        // all ones + 1: carry out of the top, with latency measurement
        send1('1, W'(1), 1'b0);
        lat = 0;
        while (!valid_out && lat < 20) begin @(negedge clk); lat++; end
        chk("latency", (W+1)'(lat), (W+1)'(WORDS + 1));
        wait_idle1();

        send1({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);
        wait_idle1();
        send1('0, '0, 1'b1);
        wait_idle1();

        // hold the result with ready_in low while poking valid_in
        ready_in = 1'b0;
        send1(rnd_word(), rnd_word(), 1'($urandom));
        lat = 0;
        while (!valid_out && lat < 20) begin @(negedge clk); lat++; end
        chk("hold_valid_seen", (W+1)'(valid_out), 1);
        hs = s_out; hc = c_out; hovf = ovf_out;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            valid_in = 1'($urandom); a_in = rnd_word();
            @(negedge clk);
            chk("hold_valid_out", (W+1)'(valid_out), 1);
            chk("hold_s_out", (W+1)'(s_out), (W+1)'(hs));
            chk("hold_c_out", (W+1)'(c_out), (W+1)'(hc));
            chk("hold_ovf_out", (W+1)'(ovf_out), (W+1)'(hovf));
            chk("hold_ready_out", (W+1)'(ready_out), 0);
        end
        @(posedge clk); #1;
        valid_in = 1'b0; ready_in = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_ready_out", (W+1)'(ready_out), 1);
        chk("release_valid_out", (W+1)'(valid_out), 0);
        @(posedge clk); #1;

        // reset in the middle of RUN discards the operation
        send1(rnd_word(), rnd_word(), 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_reset_ready_out", (W+1)'(ready_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        q1.delete();
        sent1--;
        @(negedge clk);
        chk("midrun_reset_valid_out", (W+1)'(valid_out), 0);
        chk("midrun_reset_s_out", (W+1)'(s_out), 0);
        chk("midrun_reset_c_out", (W+1)'(c_out), 0);
        chk("midrun_reset_ovf_out", (W+1)'(ovf_out), 0);
        chk("midrun_reset_ready_idle", (W+1)'(ready_out), 1);
        @(posedge clk); #1;
        send1(W'(5), W'(7), 1'b0);
        wait_idle1();

        fork
            rand1();
            rand2();
        join

        for (int k = 0; k < 500 && (q1.size() != 0 || q2.size() != 0); k++) @(negedge clk);
        chk("dut1_drained", (W+1)'(q1.size()), 0);
        chk("dut2_drained", (W+1)'(q2.size()), 0);
        chk("dut1_result_count", (W+1)'(res1), (W+1)'(sent1));
        chk("dut2_result_count", (W+1)'(res2), (W+1)'(sent2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
